// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: WISC instruction-decode stage.
// Holds the 8-entry register file, the immediate extender and the destination
// select. It feeds a registered ID/EX slot with a valid/ready handshake, flush,
// and load-use stall detection.
// Optional feature macro: DECODE_RF_BYPASS_EN. When it is defined, a writeback
// in the same cycle is visible on the read ports (write-before-read).
module decode_stage_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           instruc,
    input  logic [DATA_WIDTH-1:0] seq_PC,
    input  logic [1:0]            w_reg_cont,
    input  logic                  ext_type,
    input  logic [1:0]            len_immed,
    input  logic                  uses_rs,
    input  logic                  uses_rt,
    input  logic                  mem_read,
    input  logic                  reg_w_en,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [2:0]            wb_reg,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] seq_PC_out,
    output logic [DATA_WIDTH-1:0] ext_out,
    output logic [DATA_WIDTH-1:0] data_1,
    output logic [DATA_WIDTH-1:0] data_2,
    output logic [2:0]            w_reg_pipe,
    output logic                  mem_read_out,
    output logic                  reg_w_en_out
);

    localparam int REG_AW = $clog2(NUM_REGS);

    // Immediate extension: pick the field named by len, then sign- or zero-extend it.
    function automatic logic [DATA_WIDTH-1:0] ext_imm(
        input logic [15:0] ins,
        input logic [1:0]  len,
        input logic        sx
    );
        logic signed [DATA_WIDTH-1:0] s_val;
        logic        [DATA_WIDTH-1:0] z_val;
        case (len)
            2'b00: begin
                s_val = DATA_WIDTH'($signed(ins[4:0]));
                z_val = DATA_WIDTH'(ins[4:0]);
            end
            2'b01: begin
                s_val = DATA_WIDTH'($signed(ins[7:0]));
                z_val = DATA_WIDTH'(ins[7:0]);
            end
            2'b10: begin
                s_val = DATA_WIDTH'($signed(ins[10:0]));
                z_val = DATA_WIDTH'(ins[10:0]);
            end
            default: begin
                s_val = '0;
                z_val = '0;
            end
        endcase
        return sx ? $unsigned(s_val) : z_val;
    endfunction

    logic [DATA_WIDTH-1:0] rf [NUM_REGS];

    logic [2:0]            rs_sel_p0;
    logic [2:0]            rt_sel_p0;
    logic [DATA_WIDTH-1:0] rd_1_p0;
    logic [DATA_WIDTH-1:0] rd_2_p0;
    logic [2:0]            dest_p0;
    logic                  hazard_p0;
    logic                  accept_p0;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] seq_pc_p1;
    logic [DATA_WIDTH-1:0] ext_p1;
    logic [DATA_WIDTH-1:0] data_1_p1;
    logic [DATA_WIDTH-1:0] data_2_p1;
    logic [2:0]            w_reg_p1;
    logic                  mem_read_p1;
    logic                  reg_w_en_p1;

    assign rs_sel_p0 = instruc[10:8];
    assign rt_sel_p0 = instruc[7:5];

`ifdef DECODE_RF_BYPASS_EN
    assign rd_1_p0 = (wb_en && wb_reg == rs_sel_p0) ? wb_data : rf[rs_sel_p0];
    assign rd_2_p0 = (wb_en && wb_reg == rt_sel_p0) ? wb_data : rf[rt_sel_p0];
`else
    assign rd_1_p0 = rf[rs_sel_p0];
    assign rd_2_p0 = rf[rt_sel_p0];
`endif

    // Destination register select from the instruction fields.
    always_comb begin
        dest_p0 = 3'd7;
        case (w_reg_cont)
            2'b00:   dest_p0 = instruc[7:5];
            2'b01:   dest_p0 = instruc[4:2];
            2'b10:   dest_p0 = instruc[10:8];
            default: dest_p0 = 3'd7;
        endcase
    end

    // A load still in ID/EX whose target is read by the incoming instruction must stall one slot.
    assign hazard_p0 = out_valid && mem_read_out &&
                       ((uses_rs && rs_sel_p0 == w_reg_p1) ||
                        (uses_rt && rt_sel_p0 == w_reg_p1));
    assign in_ready  = !flush && !hazard_p0 && (!vld_p1 || out_ready);
    assign accept_p0 = in_valid && in_ready;

    // Register file: single write port, cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[REG_AW'(wb_reg)] <= wb_data;
        end
    end

    // ---- ID/EX boundary: flush > accept > drain > hold ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            seq_pc_p1   <= '0;
            ext_p1      <= '0;
            data_1_p1   <= '0;
            data_2_p1   <= '0;
            w_reg_p1    <= '0;
            mem_read_p1 <= 1'b0;
            reg_w_en_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1      <= 1'b1;
            seq_pc_p1   <= seq_PC;
            ext_p1      <= ext_imm(instruc, len_immed, ext_type);
            data_1_p1   <= rd_1_p0;
            data_2_p1   <= rd_2_p0;
            w_reg_p1    <= dest_p0;
            mem_read_p1 <= mem_read;
            reg_w_en_p1 <= reg_w_en;
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid    = vld_p1;
    assign seq_PC_out   = seq_pc_p1;
    assign ext_out      = ext_p1;
    assign data_1       = data_1_p1;
    assign data_2       = data_2_p1;
    assign w_reg_pipe   = w_reg_p1;
    assign mem_read_out = mem_read_p1 && vld_p1;
    assign reg_w_en_out = reg_w_en_p1 && vld_p1;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios followed by random traffic.
// Everything is checked against a transaction-level reference model.
module tb_decode_stage_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instruc;
    logic [15:0] seq_PC;
    logic [1:0]  w_reg_cont;
    logic        ext_type;
    logic [1:0]  len_immed;
    logic        uses_rs;
    logic        uses_rt;
    logic        mem_read;
    logic        reg_w_en;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] seq_PC_out;
    logic [15:0] ext_out;
    logic [15:0] data_1;
    logic [15:0] data_2;
    logic [2:0]  w_reg_pipe;
    logic        mem_read_out;
    logic        reg_w_en_out;

    decode_stage_pipe #(.DATA_WIDTH(16), .NUM_REGS(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruc(instruc), .seq_PC(seq_PC), .w_reg_cont(w_reg_cont),
        .ext_type(ext_type), .len_immed(len_immed), .uses_rs(uses_rs),
        .uses_rt(uses_rt), .mem_read(mem_read), .reg_w_en(reg_w_en),
        .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .seq_PC_out(seq_PC_out),
        .ext_out(ext_out), .data_1(data_1), .data_2(data_2),
        .w_reg_pipe(w_reg_pipe), .mem_read_out(mem_read_out),
        .reg_w_en_out(reg_w_en_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: register contents plus the one instruction held for EX.
    logic [15:0] m_rf [8];
    logic        m_vld;
    logic [15:0] m_pc, m_ext, m_d1, m_d2;
    logic [2:0]  m_wr;
    logic        m_mr, m_rw;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_ext(input logic [15:0] ins, input logic [1:0] len, input logic sx);
        int n, v;
        case (len)
            2'd0:    n = 5;
            2'd1:    n = 8;
            2'd2:    n = 11;
            default: n = 0;
        endcase
        if (n == 0) return 16'h0000;
        v = int'(ins) % (1 << n);
        if (sx && v >= (1 << (n - 1))) v = v - (1 << n);
        return 16'(v);
    endfunction

    function automatic logic [2:0] exp_dest(input logic [15:0] ins, input logic [1:0] wc);
        int sh;
        case (wc)
            2'd0:    sh = 5;
            2'd1:    sh = 2;
            2'd2:    sh = 8;
            default: return 3'd7;
        endcase
        return 3'((int'(ins) >> sh) & 7);
    endfunction

    function automatic logic [15:0] rd_model(input logic [2:0] r);
`ifdef DECODE_RF_BYPASS_EN
        if (wb_en && wb_reg == r) return wb_data;
`endif
        return m_rf[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_vld = 0; m_pc = 0; m_ext = 0; m_d1 = 0; m_d2 = 0; m_wr = 0; m_mr = 0; m_rw = 0;
    endtask

    task automatic set_idle();
        in_valid = 0; instruc = 0; seq_PC = 0; w_reg_cont = 0; ext_type = 0;
        len_immed = 0; uses_rs = 0; uses_rt = 0; mem_read = 0; reg_w_en = 0;
        flush = 0; wb_en = 0; wb_reg = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic check_outputs();
        chk_eq("out_valid", out_valid, m_vld);
        chk_eq("mem_read_out", mem_read_out, m_vld & m_mr);
        chk_eq("reg_w_en_out", reg_w_en_out, m_vld & m_rw);
        if (m_vld) begin
            chk_eq("seq_PC_out", seq_PC_out, m_pc);
            chk_eq("ext_out", ext_out, m_ext);
            chk_eq("data_1", data_1, m_d1);
            chk_eq("data_2", data_2, m_d2);
            chk_eq("w_reg_pipe", w_reg_pipe, m_wr);
        end
    endtask

    // Inputs are already driven just after a falling edge; this checks in_ready,
    // advances the model across one rising edge and checks the new outputs.
    task automatic step();
        logic hz, rdy;
        logic [15:0] r1, r2;
        #1;
        hz  = m_vld && m_mr && ((uses_rs && instruc[10:8] == m_wr) ||
                                (uses_rt && instruc[7:5] == m_wr));
        rdy = !flush && !hz && (!m_vld || out_ready);
        chk_eq("in_ready", in_ready, rdy);
        r1 = rd_model(instruc[10:8]);
        r2 = rd_model(instruc[7:5]);
        if (flush) begin
            m_vld = 0;
        end else if (in_valid && rdy) begin
            m_vld = 1; m_pc = seq_PC; m_ext = exp_ext(instruc, len_immed, ext_type);
            m_d1 = r1; m_d2 = r2; m_wr = exp_dest(instruc, w_reg_cont);
            m_mr = mem_read; m_rw = reg_w_en;
        end else if (m_vld && out_ready) begin
            m_vld = 0;
        end
        if (wb_en) m_rf[wb_reg] = wb_data;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    logic [15:0] saved_pc, saved_d1, saved_ext;

    initial begin
        set_idle();
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_seq_PC_out", seq_PC_out, 0);
        chk_eq("rst_ext_out", ext_out, 0);
        chk_eq("rst_data_1", data_1, 0);
        chk_eq("rst_data_2", data_2, 0);
        chk_eq("rst_w_reg_pipe", w_reg_pipe, 0);
        chk_eq("rst_ctrl", {mem_read_out, reg_w_en_out}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Writeback r2, then decode an instruction that reads r2.
        set_idle(); wb_en = 1; wb_reg = 3'd2; wb_data = 16'hBEEF;
        step();
        set_idle(); in_valid = 1; instruc = 16'hD240; uses_rs = 1; seq_PC = 16'h0102;
        step();
        chk_eq("t2_data_1", data_1, 16'hBEEF);
        chk_eq("t2_out_valid", out_valid, 1);

        // Same-edge writeback and read of r5.
        set_idle(); in_valid = 1; instruc = 16'h0500; uses_rs = 1; seq_PC = 16'h0104;
        wb_en = 1; wb_reg = 3'd5; wb_data = 16'h1234;
        step();
`ifdef DECODE_RF_BYPASS_EN
        chk_eq("t3_data_1", data_1, 16'h1234);
`else
        chk_eq("t3_data_1", data_1, 16'h0000);
`endif

        // Load into r4, followed by a dependent instruction: one stall, one bubble.
        set_idle(); in_valid = 1; instruc = 16'h0400; w_reg_cont = 2'b10;
        mem_read = 1; reg_w_en = 1; seq_PC = 16'h0106;
        step();
        chk_eq("t4_load_dest", w_reg_pipe, 3'd4);
        set_idle(); in_valid = 1; instruc = 16'h0400; uses_rs = 1; seq_PC = 16'h0108;
        #1 chk_eq("t4_stall", in_ready, 0);
        step();
        chk_eq("t4_bubble", out_valid, 0);
        step();
        chk_eq("t4_accept", out_valid, 1);
        chk_eq("t4_accept_pc", seq_PC_out, 16'h0108);

        // Backpressure from EX for three cycles.
        set_idle(); in_valid = 1; instruc = 16'h1234; seq_PC = 16'h010A; out_ready = 0;
        saved_pc = seq_PC_out; saved_d1 = data_1; saved_ext = ext_out;
        for (int i = 0; i < 3; i++) begin
            #1 chk_eq("t5_in_ready", in_ready, 0);
            step();
            chk_eq("t5_hold_pc", seq_PC_out, saved_pc);
            chk_eq("t5_hold_d1", data_1, saved_d1);
            chk_eq("t5_hold_ext", ext_out, saved_ext);
        end
        out_ready = 1;
        step();
        chk_eq("t5_release_pc", seq_PC_out, 16'h010A);

        // Flush kills ID/EX and refuses the IF/ID instruction.
        set_idle(); in_valid = 1; flush = 1; instruc = 16'h0222; seq_PC = 16'h010C;
        #1 chk_eq("t6_in_ready", in_ready, 0);
        step();
        chk_eq("t6_flushed", out_valid, 0);
        set_idle(); in_valid = 1; instruc = 16'h0010; ext_type = 1; len_immed = 2'b00;
        seq_PC = 16'h010E;
        step();
        chk_eq("t6_ext_out", ext_out, 16'hFFF0);

        // Asynchronous reset while ID/EX is full; register file must be cleared.
        set_idle(); in_valid = 1; instruc = 16'h0300; uses_rs = 1; seq_PC = 16'h0110;
        wb_en = 1; wb_reg = 3'd3; wb_data = 16'hAAAA;
        step();
        set_idle(); in_valid = 1; instruc = 16'h0300; uses_rs = 1; seq_PC = 16'h0112;
        step();
        chk_eq("t1_pre_valid", out_valid, 1);
        chk_eq("t1_pre_r3", data_1, 16'hAAAA);
        rst = 1'b0;
        #1;
        chk_eq("t1_rst_valid", out_valid, 0);
        chk_eq("t1_rst_data_1", data_1, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle(); in_valid = 1; instruc = 16'h0300; uses_rs = 1; seq_PC = 16'h0114;
        step();
        chk_eq("t1_r3_cleared", data_1, 16'h0000);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            instruc    = 16'($urandom);
            seq_PC     = 16'($urandom);
            w_reg_cont = 2'($urandom);
            ext_type   = 1'($urandom);
            len_immed  = 2'($urandom);
            uses_rs    = 1'($urandom);
            uses_rt    = 1'($urandom);
            mem_read   = 1'($urandom);
            reg_w_en   = 1'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            wb_en      = 1'($urandom);
            wb_reg     = 3'($urandom);
            wb_data    = 16'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
